uart_arbiter: RTL and testbench

UART_ARBITER -- requirements
Module: uart_arbiter

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rr_pick.sv | 12 +
 rtl/uart_arbiter.sv | 89 ++++++++
 tb/tb_uart_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and op codes for the uart arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, ACK} s_uart_arb;
  localparam logic OP_TX = 1'b0;
  localparam logic OP_RX = 1'b1;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: 2-way round-robin pick; on a tie the requester that did not win last time goes next
module uart_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       id
);
  always_comb begin
    valid = |req;
    id    = &req ? ~last_grant : req[1];
  end
endmodule

// File: rtl/uart_arbiter.sv
// uart_arbiter: shares one uart byte port between the CPU core (0) and the debug loader (1)
module uart_arbiter
  import uart_pkg::*;
#(
  parameter int TIMEOUT = 1048576,
  parameter int N_REQ   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_op,
  input  logic [N_REQ-1:0][7:0] req_data,
  output logic [N_REQ-1:0]      ack,
  output logic [7:0]            ack_data,
  output logic                  t_valid,
  output logic                  r_valid,
  output logic [7:0]            t_data,
  input  logic                  tx_done,
  input  logic                  rx_done,
  input  logic [7:0]            r_data,
  output logic                  grant_id,
  output logic                  busy,
  output logic                  hung
);
  // the counter saturates one below TIMEOUT so the default still fits in 20 bits
  localparam logic [19:0] TLIM = 20'(TIMEOUT - 1);
  s_uart_arb   state;
  logic        op_q;
  logic        last_grant;
  logic [19:0] cnt;
  logic        pick_valid;
  logic        pick_id;
  logic        done;
  uart_rr_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .id         (pick_id)
  );
  assign done = (op_q == OP_RX) ? rx_done : tx_done;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      op_q       <= OP_TX;
      ack        <= '0;
      ack_data   <= '0;
      t_valid    <= 1'b0;
      r_valid    <= 1'b0;
      t_data     <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
      hung       <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          state    <= ISSUE;
          busy     <= 1'b1;
          grant_id <= pick_id;
          op_q     <= req_op[pick_id];
          t_data   <= req_data[pick_id];
          t_valid  <= req_op[pick_id] == OP_TX;
          r_valid  <= req_op[pick_id] == OP_RX;
        end
        ISSUE, BUSY: begin
          t_valid <= 1'b0;
          r_valid <= 1'b0;
          // a done in ISSUE completes immediately; once hung we keep waiting for it
          if (done) begin
            state         <= ACK;
            ack[grant_id] <= 1'b1;
            if (op_q == OP_RX) ack_data <= r_data;
          end else if (state == ISSUE) begin
            state <= BUSY;
            cnt   <= '0;
          end else if (cnt == TLIM) hung <= 1'b1;
          else cnt <= cnt + 20'd1;
        end
        ACK: begin
          ack        <= '0;
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_arbiter.sv
// tb_uart_arbiter: directed table plus hand sequences for tie-break, spurious done, timeout and reset
module tb_uart_arbiter;
  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [1:0]      req = '0;
  logic [1:0]      req_op = '0;
  logic [1:0][7:0] req_data = '0;
  logic            tx_done = 1'b0;
  logic            rx_done = 1'b0;
  logic [7:0]      r_data = '0;
  logic [1:0]      ack;
  logic [7:0]      ack_data;
  logic            t_valid;
  logic            r_valid;
  logic [7:0]      t_data;
  logic            grant_id;
  logic            busy;
  logic            hung;
  int errors = 0;
  int checks = 0;
  int tv_cnt = 0;
  int rv_cnt = 0;
  int both_cnt = 0;
  typedef struct {
    logic       who;
    logic       op;
    logic [7:0] data;
    int         dly;
    logic [7:0] rdata;
    logic [1:0] eack;
    logic [7:0] eadata;
  } vec_t;
  vec_t vec[4];
  uart_arbiter #(.TIMEOUT(64)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .req_op   (req_op),
    .req_data (req_data),
    .ack      (ack),
    .ack_data (ack_data),
    .t_valid  (t_valid),
    .r_valid  (r_valid),
    .t_data   (t_data),
    .tx_done  (tx_done),
    .rx_done  (rx_done),
    .r_data   (r_data),
    .grant_id (grant_id),
    .busy     (busy),
    .hung     (hung)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (t_valid) tv_cnt <= tv_cnt + 1;
    if (r_valid) rv_cnt <= rv_cnt + 1;
    if (t_valid && r_valid) both_cnt <= both_cnt + 1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_start(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(t_valid || r_valid) && n < 20);
  endtask
  initial begin
    int n;
    int tv0;
    int rv0;
    logic id;
    logic exp_id[4];
    vec[0] = '{1'b0, 1'b0, 8'h41, 30, 8'h00, 2'b01, 8'h00};
    vec[1] = '{1'b1, 1'b1, 8'h33, 4,  8'h5a, 2'b10, 8'h5a};
    vec[2] = '{1'b1, 1'b0, 8'hc3, 2,  8'h00, 2'b10, 8'h5a};
    vec[3] = '{1'b0, 1'b1, 8'h19, 0,  8'ha5, 2'b01, 8'ha5};
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    tick();
    tick();
    check("rst ack", 32'(ack), 32'(0));
    check("rst busy", 32'(busy), 32'(0));
    check("rst tv/rv", 32'({t_valid, r_valid}), 32'(0));
    check("rst t_data", 32'(t_data), 32'(0));
    check("rst grant_id", 32'(grant_id), 32'(0));
    check("rst hung", 32'(hung), 32'(0));
    check("rst ack_data", 32'(ack_data), 32'(0));
    rstn = 1'b1;
    tick();
    check("idle no req", 32'(busy), 32'(0));
    for (int i = 0; i < 4; i++) begin
      tv0 = tv_cnt;
      rv0 = rv_cnt;
      req_op[vec[i].who] = vec[i].op;
      req_data[vec[i].who] = vec[i].data;
      req[vec[i].who] = 1'b1;
      wait_start(n);
      check($sformatf("v%0d latency", i), 32'(n), 32'(1));
      check($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(vec[i].who));
      check($sformatf("v%0d t_data", i), 32'(t_data), 32'(vec[i].data));
      repeat (vec[i].dly) tick();
      r_data = vec[i].rdata;
      if (vec[i].op) rx_done = 1'b1;
      else tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      rx_done = 1'b0;
      check($sformatf("v%0d ack", i), 32'(ack), 32'(vec[i].eack));
      check($sformatf("v%0d ack_data", i), 32'(ack_data), 32'(vec[i].eadata));
      req[vec[i].who] = 1'b0;
      req_data[vec[i].who] = ~vec[i].data;
      tick();
      check($sformatf("v%0d ack clr", i), 32'(ack), 32'(0));
      check($sformatf("v%0d busy clr", i), 32'(busy), 32'(0));
      check($sformatf("v%0d t_data hold", i), 32'(t_data), 32'(vec[i].data));
      check($sformatf("v%0d tv pulses", i), 32'(tv_cnt - tv0), vec[i].op ? 32'(0) : 32'(1));
      check($sformatf("v%0d rv pulses", i), 32'(rv_cnt - rv0), vec[i].op ? 32'(1) : 32'(0));
    end
    // spurious rx_done while a TX is outstanding
    req_op[0] = 1'b0;
    req_data[0] = 8'h77;
    req[0] = 1'b1;
    wait_start(n);
    check("spur start", 32'(t_valid), 32'(1));
    repeat (3) tick();
    r_data = 8'hee;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    check("spur no ack", 32'(ack), 32'(0));
    check("spur busy", 32'(busy), 32'(1));
    repeat (2) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("spur ack", 32'(ack), 32'(1));
    check("spur ack_data hold", 32'(ack_data), 32'(8'ha5));
    req[0] = 1'b0;
    tick();
    // round robin from reset, both requesters contending
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tv0 = tv_cnt;
    req_op = 2'b00;
    req_data = {8'h22, 8'h11};
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_start(n);
      check($sformatf("rr%0d latency", g), 32'(n), 32'(1));
      check($sformatf("rr%0d grant", g), 32'(grant_id), 32'(exp_id[g]));
      repeat (3) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      id = exp_id[g];
      check($sformatf("rr%0d ack", g), 32'(ack), 32'(1) << id);
      req[id] = 1'b0;
      tick();
      if (g < 2) req[id] = 1'b1;
    end
    repeat (3) tick();
    check("rr total issues", 32'(tv_cnt - tv0), 32'(4));
    check("rr idle", 32'(busy), 32'(0));
    // timeout: no done ever arrives; req dropped after grant
    req_op[0] = 1'b0;
    req[0] = 1'b1;
    wait_start(n);
    check("to start", 32'(t_valid), 32'(1));
    req[0] = 1'b0;
    repeat (64) tick();
    check("to hung early", 32'(hung), 32'(0));
    tick();
    check("to hung", 32'(hung), 32'(1));
    check("to busy", 32'(busy), 32'(1));
    repeat (5) tick();
    check("to hung sticky", 32'(hung), 32'(1));
    check("to busy held", 32'(busy), 32'(1));
    rstn = 1'b0;
    #1;
    check("to async hung", 32'(hung), 32'(0));
    check("to async busy", 32'(busy), 32'(0));
    tick();
    rstn = 1'b1;
    tick();
    check("to idle", 32'(busy), 32'(0));
    // reset mid-BUSY, then a late tx_done in IDLE
    req[0] = 1'b1;
    wait_start(n);
    check("rb start", 32'(t_valid), 32'(1));
    repeat (3) tick();
    rstn = 1'b0;
    req[0] = 1'b0;
    #1;
    check("rb busy", 32'(busy), 32'(0));
    tick();
    rstn = 1'b1;
    tv0 = tv_cnt;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("rb no ack", 32'(ack), 32'(0));
    repeat (3) tick();
    check("rb no ack late", 32'(ack), 32'(0));
    check("rb no issue", 32'(tv_cnt - tv0), 32'(0));
    check("rb idle", 32'(busy), 32'(0));
    check("tv&rv never both", 32'(both_cnt), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
